cdcm8_rx_aligner: RTL and testbench

- Receive-side counterpart of the CDCM-8 transmitter.
- Takes 8-bit parallel words from the input deserializer, one word per clock, first-received bit in MSB.
- Finds the symbol boundary by scanning bit rotations against the training/idle waveform 8'hF0, which the transmitter emits while in reset.
- Once locked, decodes each aligned symbol as idle, data 0, data 1 or error, and monitors for loss of lock.

---
 rtl/cdcm8_rx_aligner_if.sv | 24 ++
 rtl/cdcm8_rx_aligner.sv | 144 ++++++++++++++
 tb/tb_cdcm8_rx_aligner.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/cdcm8_rx_aligner_if.sv
// rtl/cdcm8_rx_aligner_if.sv - word-in / aligned-symbol-out bundle for the CDCM-8 receive aligner
interface cdcm8_rx_aligner_if;
    logic [7:0] dInFromDevice;
    logic [7:0] dOutAligned;
    logic       symValid;
    logic       symData;
    logic       symIdle;
    logic       symError;
    logic [2:0] bitSlipNum;
    logic       isLocked;
    logic       scanFailed;

    modport master (
        output dInFromDevice,
        input  dOutAligned, symValid, symData, symIdle, symError,
        input  bitSlipNum, isLocked, scanFailed
    );

    modport slave (
        input  dInFromDevice,
        output dOutAligned, symValid, symData, symIdle, symError,
        output bitSlipNum, isLocked, scanFailed
    );
endinterface

// File: rtl/cdcm8_rx_aligner.sv
// rtl/cdcm8_rx_aligner.sv - CDCM-8 receive word aligner: rotation search on F0 idle, lock, symbol decode
module cdcm8_rx_aligner #(
    parameter int kDevW     = 8,
    parameter int kCheckLen = 64,
    parameter int kLossThr  = 4,
    parameter int kMaxSweep = 16
) (
    input  logic               clkIn,
    input  logic               rstN,
    cdcm8_rx_aligner_if.slave  bus
);
    localparam logic [7:0] SYM_IDLE  = 8'hF0;
    localparam logic [7:0] SYM_ONE   = 8'hF8;
    localparam logic [7:0] SYM_ZERO  = 8'hE0;
    localparam logic [7:0] LAST_MATCH = 8'(kCheckLen - 1);
    localparam logic [3:0] LAST_ERR   = 4'(kLossThr - 1);
    localparam logic [7:0] SWEEP_LIM  = 8'(kMaxSweep);
    localparam logic [1:0] FILL_DONE  = 2'd3;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state;
    logic [kDevW-1:0]   cur_word;
    logic [kDevW-1:0]   prev_word;
    logic [kDevW-1:0]   stage1;
    logic [2:0]         rot;
    logic [1:0]         fill_cnt;
    logic [7:0]         match_cnt;
    logic [7:0]         sweep_cnt;
    logic [3:0]         err_cnt;
    logic               sym_valid;
    logic               sym_data;
    logic               sym_idle;
    logic               sym_error;
    logic               is_locked;
    logic               scan_failed;

    logic [2*kDevW-1:0] win;
    logic [2*kDevW-1:0] win_shifted;
    logic [kDevW-1:0]   aligned;
    logic               stage1_err;
    logic               in_locked;

    function automatic logic is_symbol_error(input logic [7:0] w);
        return !(w == SYM_IDLE || w == SYM_ONE || w == SYM_ZERO);
    endfunction

    // Rotation r picks win[15-r -: 8]; shifting left by r brings that slice to the top byte.
    assign win         = {prev_word, cur_word};
    assign win_shifted = win << rot;
    assign aligned     = win_shifted[2*kDevW-1 -: kDevW];
    assign stage1_err  = is_symbol_error(stage1);
    assign in_locked   = (state == LOCKED);

    always_ff @(posedge clkIn or negedge rstN) begin
        if (!rstN) begin
            state       <= SEARCH;
            cur_word    <= '0;
            prev_word   <= '0;
            stage1      <= '0;
            rot         <= '0;
            fill_cnt    <= '0;
            match_cnt   <= '0;
            sweep_cnt   <= '0;
            err_cnt     <= '0;
            sym_valid   <= 1'b0;
            sym_data    <= 1'b0;
            sym_idle    <= 1'b0;
            sym_error   <= 1'b0;
            is_locked   <= 1'b0;
            scan_failed <= 1'b0;
        end else begin
            cur_word  <= bus.dInFromDevice;
            prev_word <= cur_word;
            stage1    <= aligned;

            // Decode stage reports the symbol the FSM examines this cycle.
            sym_valid <= in_locked;
            is_locked <= in_locked;
            sym_idle  <= in_locked && (stage1 == SYM_IDLE);
            sym_data  <= in_locked && (stage1 == SYM_ONE);
            sym_error <= in_locked && stage1_err;

            case (state)
                SEARCH: begin
                    // fill_cnt holds off evaluation until stage1 reflects the current rotation.
                    if (fill_cnt != FILL_DONE) begin
                        fill_cnt <= fill_cnt + 2'd1;
                    end else if (stage1 == SYM_IDLE) begin
                        if (match_cnt == LAST_MATCH) begin
                            state       <= LOCKED;
                            match_cnt   <= '0;
                            err_cnt     <= '0;
                            scan_failed <= 1'b0;
                        end else begin
                            match_cnt <= match_cnt + 8'd1;
                        end
                    end else begin
                        match_cnt <= '0;
                        rot       <= rot + 3'd1;
                        fill_cnt  <= 2'd1;
                        if (rot == 3'd7) begin
                            if (sweep_cnt != 8'hFF) begin
                                sweep_cnt <= sweep_cnt + 8'd1;
                            end
                            if (8'(sweep_cnt + 8'd1) == SWEEP_LIM) begin
                                scan_failed <= 1'b1;
                            end
                        end
                    end
                end

                LOCKED: begin
                    if (stage1_err) begin
                        if (err_cnt == LAST_ERR) begin
                            state     <= SEARCH;
                            match_cnt <= '0;
                            sweep_cnt <= '0;
                            err_cnt   <= '0;
                        end else begin
                            err_cnt <= err_cnt + 4'd1;
                        end
                    end else begin
                        err_cnt <= '0;
                    end
                end

                default: state <= SEARCH;
            endcase
        end
    end

    assign bus.dOutAligned = stage1;
    assign bus.symValid    = sym_valid;
    assign bus.symData     = sym_data;
    assign bus.symIdle     = sym_idle;
    assign bus.symError    = sym_error;
    assign bus.bitSlipNum  = rot;
    assign bus.isLocked    = is_locked;
    assign bus.scanFailed  = scan_failed;
endmodule

// File: tb/tb_cdcm8_rx_aligner.sv
// tb/tb_cdcm8_rx_aligner.sv - directed, table-driven bench for the CDCM-8 receive aligner
module tb_cdcm8_rx_aligner;
    localparam int CHECK_LEN = 16;
    localparam int LOSS_THR  = 4;
    localparam int MAX_SWEEP = 2;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    cdcm8_rx_aligner_if bus ();

    cdcm8_rx_aligner #(
        .kDevW     (8),
        .kCheckLen (CHECK_LEN),
        .kLossThr  (LOSS_THR),
        .kMaxSweep (MAX_SWEEP)
    ) dut (
        .clkIn (clk),
        .rstN  (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_aligned;
        logic       exp_valid;
        logic       exp_data;
        logic       exp_idle;
        logic       exp_error;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cycle(input logic [7:0] w);
        bus.dInFromDevice = w;
        @(negedge clk);
    endtask

    function automatic logic [16:0] all_outputs();
        return {bus.dOutAligned, bus.symValid, bus.symData, bus.symIdle, bus.symError,
                bus.bitSlipNum, bus.isLocked, bus.scanFailed};
    endfunction

    task automatic reset_and_lock(input logic [7:0] w, input int bound, output bit locked);
        rst_n = 1'b0;
        bus.dInFromDevice = w;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        locked = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bus.isLocked) begin
                locked = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit         locked;
        bit         held;
        bit         dropped;
        logic [2:0] last_r;
        logic [11:0] seq_code;
        logic [7:0] r_mask;

        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.dInFromDevice = 8'hF0;

        vecs[0] = '{8'hF8, 8'hF8, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'hE0, 8'hE0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'hF8, 8'hF8, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'hF0, 8'hF0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'hAA, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'hE0, 8'hE0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{8'hF0, 8'hF0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{8'hF8, 8'hF8, 1'b1, 1'b1, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        check("reset_outputs", 32'(all_outputs()), 32'h0);

        // Aligned F0 stream locks at r=0 within kCheckLen+4 cycles of release.
        reset_and_lock(8'hF0, CHECK_LEN + 4, locked);
        check("t1_lock", 32'(locked), 32'h1);
        check("t1_bitslip", 32'(bus.bitSlipNum), 32'h0);
        check("t1_sym_idle", 32'(bus.symIdle), 32'h1);
        check("t1_sym_valid", 32'(bus.symValid), 32'h1);

        // F0 rotated in the serial stream arrives as 1E; search must step 0->1->2->3.
        rst_n = 1'b0;
        bus.dInFromDevice = 8'h1E;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        locked = 1'b0;
        last_r = 3'd0;
        seq_code = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.bitSlipNum != last_r) begin
                seq_code = {seq_code[8:0], bus.bitSlipNum};
                last_r = bus.bitSlipNum;
            end
            if (bus.isLocked) begin
                locked = 1'b1;
                break;
            end
        end
        check("t2_lock", 32'(locked), 32'h1);
        check("t2_r_sequence", 32'(seq_code), 32'h053);
        check("t2_bitslip", 32'(bus.bitSlipNum), 32'h3);
        check("t2_aligned", 32'(bus.dOutAligned), 32'hF0);

        // Decode table at r=0: aligned word 2 cycles later, symbol 3 cycles later.
        reset_and_lock(8'hF0, CHECK_LEN + 4, locked);
        check("t3_lock", 32'(locked), 32'h1);
        for (int i = 0; i < 11; i++) begin
            cycle(i < 8 ? vecs[i].din : 8'hF0);
            if (i >= 2 && i - 2 < 8) begin
                check($sformatf("t3_aligned_%0d", i - 2), 32'(bus.dOutAligned),
                      32'(vecs[i - 2].exp_aligned));
            end
            if (i >= 3) begin
                check($sformatf("t3_sym_%0d", i - 3),
                      32'({bus.symValid, bus.symData, bus.symIdle, bus.symError}),
                      32'({vecs[i - 3].exp_valid, vecs[i - 3].exp_data,
                           vecs[i - 3].exp_idle, vecs[i - 3].exp_error}));
            end
        end

        // kLossThr-1 errors then a valid symbol must not drop lock.
        for (int i = 0; i < LOSS_THR - 1; i++) cycle(8'hAA);
        held = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle(8'hF0);
            if (!bus.isLocked) held = 1'b0;
        end
        check("t4_lock_held", 32'(held), 32'h1);

        // kLossThr consecutive errors force re-search at the same rotation.
        for (int i = 0; i < LOSS_THR; i++) cycle(8'hAA);
        dropped = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cycle(8'hF0);
            if (!bus.isLocked) begin
                dropped = 1'b1;
                break;
            end
        end
        check("t4_lock_lost", 32'(dropped), 32'h1);
        check("t4_sym_valid_off", 32'(bus.symValid), 32'h0);
        check("t4_bitslip_kept", 32'(bus.bitSlipNum), 32'h0);

        // No F0 anywhere in a 55 stream: r sweeps all rotations and scanFailed eventually sets.
        rst_n = 1'b0;
        bus.dInFromDevice = 8'h55;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        r_mask = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            r_mask[bus.bitSlipNum] = 1'b1;
        end
        check("t5_all_rotations", 32'(r_mask), 32'hFF);
        check("t5_scan_not_early", 32'(bus.scanFailed), 32'h0);
        held = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.scanFailed) begin
                held = 1'b1;
                break;
            end
        end
        check("t5_scan_failed", 32'(held), 32'h1);
        check("t5_not_locked", 32'(bus.isLocked), 32'h0);
        locked = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cycle(8'hF0);
            if (bus.isLocked) begin
                locked = 1'b1;
                break;
            end
        end
        check("t5_relock", 32'(locked), 32'h1);
        check("t5_scan_cleared", 32'(bus.scanFailed), 32'h0);
        check("t5_relock_bitslip", 32'(bus.bitSlipNum), 32'h0);

        // Reset asserted between clock edges clears outputs without a clock.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_reset", 32'(all_outputs()), 32'h0);
        @(negedge clk);
        reset_and_lock(8'hF0, CHECK_LEN + 4, locked);
        check("t6_relock", 32'(locked), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
